// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the
// unified memory. slave = arbiter view, master = core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ack;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_ack;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for instruction fetch and load/store, data
// priority with a bounded data streak so fetch cannot starve.
//
// state | meaning
// IDLE  | sample requests, grant and latch the winning access
// ISSUE | one-cycle mem_en strobe from the latched access
// WAIT  | MEM_LATENCY-1 cycles waiting for mem_rdata (skipped when latency is 1)
// RESP  | one-cycle ack to the owner, rdata forwarded from memory
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_D_STREAK = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W     = DATA_W / 8;
  localparam int WAIT_CYC = MEM_LATENCY - 1;
  localparam int CW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int SW       = $clog2(MAX_D_STREAK + 1);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_streak;
  logic [CW-1:0]     r_wait_cnt;
  logic              r_owner_d;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_resp;
  logic              w_if_ack;
  logic              w_d_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && (r_streak == STREAK_MAX))) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ISSUE;
        end else if (bus.if_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (WAIT_CYC == 0) w_state_nxt = RESP;
        else               w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_wait_cnt == '0) w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_streak   <= '0;
      r_wait_cnt <= '0;
      r_owner_d  <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant_d) begin
        r_owner_d <= 1'b1;
        r_addr    <= bus.d_addr;
        r_we      <= bus.d_we;
        r_wdata   <= bus.d_wdata;
        r_be      <= bus.d_we ? bus.d_be : '1;
        // streak only counts data wins that actually held off a pending fetch
        if (!bus.if_req)                 r_streak <= '0;
        else if (r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
      end else if (w_grant_i) begin
        r_owner_d <= 1'b0;
        r_addr    <= bus.if_addr;
        r_we      <= 1'b0;
        r_wdata   <= '0;
        r_be      <= '1;
        r_streak  <= '0;
      end

      if (r_state == ISSUE)
        r_wait_cnt <= WAIT_LOAD;
      else if ((r_state == WAIT) && (r_wait_cnt != '0))
        r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  assign w_resp   = (r_state == RESP);
  assign w_if_ack = w_resp && !r_owner_d;
  assign w_d_ack  = w_resp && r_owner_d;

  assign bus.if_ack    = w_if_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.if_rdata  = w_if_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (w_d_ack && !r_we) ? bus.mem_rdata : '0;
  assign bus.mem_en    = (r_state == ISSUE);
  assign bus.mem_we    = (r_state == ISSUE) && r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (latency 1 / streak 4,
// latency 1 / streak 2, latency 3 / streak 4), each with its own memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_D_STREAK(4))
    dut_a (.i_clk(clk), .i_reset(rst), .bus(ifa));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_D_STREAK(2))
    dut_b (.i_clk(clk), .i_reset(rst), .bus(ifb));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .MAX_D_STREAK(4))
    dut_c (.i_clk(clk), .i_reset(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory models: word-indexed, byte-enable writes, preloaded during reset
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] mem_c [256];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b;
  logic [31:0] pipe_c0, pipe_c1, pipe_c2;

  always @(posedge clk) begin
    if (rst) begin
      mem_a[8'h40] <= 32'h0050_0093;
      mem_a[8'h80] <= 32'h1234_5678;
      mem_a[8'h81] <= 32'h0000_0000;
    end else if (ifa.mem_en && ifa.mem_we) begin
      for (int k = 0; k < 4; k++)
        if (ifa.mem_be[k]) mem_a[ifa.mem_addr[9:2]][8*k +: 8] <= ifa.mem_wdata[8*k +: 8];
    end
    pipe_a <= mem_a[ifa.mem_addr[9:2]];
  end
  assign ifa.mem_rdata = pipe_a;

  always @(posedge clk) begin
    pipe_b <= mem_b[ifb.mem_addr[9:2]];
  end
  assign ifb.mem_rdata = pipe_b;

  always @(posedge clk) begin
    if (rst) mem_c[8'hC0] <= 32'hCAFE_F00D;
    pipe_c0 <= mem_c[ifc.mem_addr[9:2]];
    pipe_c1 <= pipe_c0;
    pipe_c2 <= pipe_c1;
  end
  assign ifc.mem_rdata = pipe_c2;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    ifa.if_req = 0; ifa.if_addr = '0; ifa.d_req = 0; ifa.d_we = 0;
    ifa.d_addr = '0; ifa.d_wdata = '0; ifa.d_be = '0;
    ifb.if_req = 0; ifb.if_addr = '0; ifb.d_req = 0; ifb.d_we = 0;
    ifb.d_addr = '0; ifb.d_wdata = '0; ifb.d_be = '0;
    ifc.if_req = 0; ifc.if_addr = '0; ifc.d_req = 0; ifc.d_we = 0;
    ifc.d_addr = '0; ifc.d_wdata = '0; ifc.d_be = '0;
  endtask

  logic exp_d [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_reqs();
    rst = 1'b1;
    tick();
    tick();

    // reset state
    check_val("rst_mem_en",   ifa.mem_en,   0);
    check_val("rst_mem_we",   ifa.mem_we,   0);
    check_val("rst_busy",     ifa.busy,     0);
    check_val("rst_if_ack",   ifa.if_ack,   0);
    check_val("rst_d_ack",    ifa.d_ack,    0);
    check_val("rst_mem_addr", ifa.mem_addr, 0);
    check_val("rst_mem_be",   ifa.mem_be,   0);
    check_val("rst_d_rdata",  ifa.d_rdata,  0);
    rst = 1'b0;
    tick();

    // 1: single fetch
    ifa.if_req = 1; ifa.if_addr = 32'h100;
    tick();
    check_val("t1_mem_en",   ifa.mem_en,   1);
    check_val("t1_mem_we",   ifa.mem_we,   0);
    check_val("t1_mem_addr", ifa.mem_addr, 32'h100);
    check_val("t1_mem_be",   ifa.mem_be,   4'hF);
    check_val("t1_busy",     ifa.busy,     1);
    check_val("t1_early_ack", ifa.if_ack,  0);
    tick();
    check_val("t1_if_ack",   ifa.if_ack,   1);
    check_val("t1_if_rdata", ifa.if_rdata, 32'h0050_0093);
    check_val("t1_en_vs_ack", ifa.mem_en,  0);
    ifa.if_req = 0;
    tick();
    check_val("t1_busy_end", ifa.busy,     0);
    check_val("t1_ack_end",  ifa.if_ack,   0);
    check_val("t1_rdata_end", ifa.if_rdata, 0);

    // 2: simultaneous fetch and load, data wins
    ifa.if_req = 1; ifa.if_addr = 32'h100;
    ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 32'h200; ifa.d_be = 4'h5;
    tick();
    check_val("t2_c1_addr", ifa.mem_addr, 32'h200);
    check_val("t2_c1_be",   ifa.mem_be,   4'hF);
    tick();
    check_val("t2_d_ack",   ifa.d_ack,    1);
    check_val("t2_d_rdata", ifa.d_rdata,  32'h1234_5678);
    check_val("t2_no_if",   ifa.if_ack,   0);
    ifa.d_req = 0;
    tick();
    check_val("t2_c3_en",   ifa.mem_en,   0);
    check_val("t2_c3_busy", ifa.busy,     0);
    tick();
    check_val("t2_c4_en",   ifa.mem_en,   1);
    check_val("t2_c4_addr", ifa.mem_addr, 32'h100);
    tick();
    check_val("t2_if_ack",  ifa.if_ack,   1);
    check_val("t2_if_rdata", ifa.if_rdata, 32'h0050_0093);
    check_val("t2_d_rdata0", ifa.d_rdata, 0);
    ifa.if_req = 0;
    tick();

    // 3: partial store then load back
    ifa.d_req = 1; ifa.d_we = 1; ifa.d_addr = 32'h204;
    ifa.d_wdata = 32'hDEAD_BEEF; ifa.d_be = 4'b0011;
    tick();
    check_val("t3_mem_en",    ifa.mem_en,    1);
    check_val("t3_mem_we",    ifa.mem_we,    1);
    check_val("t3_mem_be",    ifa.mem_be,    4'b0011);
    check_val("t3_mem_wdata", ifa.mem_wdata, 32'hDEAD_BEEF);
    tick();
    check_val("t3_d_ack",     ifa.d_ack,     1);
    check_val("t3_d_rdata",   ifa.d_rdata,   0);
    check_val("t3_we_hold",   ifa.mem_we,    0);
    ifa.d_req = 0;
    tick();
    ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 32'h204;
    tick();
    check_val("t3_ld_be",     ifa.mem_be,    4'hF);
    check_val("t3_ld_we",     ifa.mem_we,    0);
    tick();
    check_val("t3_ld_ack",    ifa.d_ack,     1);
    check_val("t3_ld_rdata",  ifa.d_rdata,   32'h0000_BEEF);
    ifa.d_req = 0;
    tick();

    // 4: streak limit 2 with both requests held
    exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 0; exp_d[3] = 1; exp_d[4] = 1; exp_d[5] = 0;
    ifb.if_req = 1; ifb.if_addr = 32'h40;
    ifb.d_req = 1; ifb.d_we = 0; ifb.d_addr = 32'h80;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if ((n % 3) == 2) begin
        check_val($sformatf("t4_d_ack_%0d", n),  ifb.d_ack,  exp_d[n/3]);
        check_val($sformatf("t4_if_ack_%0d", n), ifb.if_ack, !exp_d[n/3]);
      end else begin
        check_val($sformatf("t4_noack_%0d", n), {ifb.d_ack, ifb.if_ack}, 0);
      end
    end
    ifb.if_req = 0; ifb.d_req = 0;
    tick();
    tick();
    check_val("t4_idle", ifb.busy, 0);

    // 5: latency 3 single load
    ifc.d_req = 1; ifc.d_we = 0; ifc.d_addr = 32'h300;
    for (int n = 1; n <= 5; n++) begin
      tick();
      check_val($sformatf("t5_en_%0d", n),   ifc.mem_en, (n == 1));
      check_val($sformatf("t5_ack_%0d", n),  ifc.d_ack,  (n == 4));
      check_val($sformatf("t5_busy_%0d", n), ifc.busy,   (n <= 4));
      if (n == 4) begin
        check_val("t5_rdata", ifc.d_rdata, 32'hCAFE_F00D);
        ifc.d_req = 0;
      end
    end

    // 6: reset during the first WAIT cycle aborts the access
    ifc.if_req = 1; ifc.if_addr = 32'h0;
    ifc.d_req = 1; ifc.d_we = 0; ifc.d_addr = 32'h300;
    tick();
    check_val("t6_c1_en", ifc.mem_en, 1);
    tick();
    check_val("t6_c2_busy",   ifc.busy,         1);
    check_val("t6_c2_streak", dut_c.r_streak,   1);
    rst = 1'b1;
    tick();
    check_val("t6_c3_en",     ifc.mem_en,       0);
    check_val("t6_c3_busy",   ifc.busy,         0);
    check_val("t6_c3_ack",    {ifc.d_ack, ifc.if_ack}, 0);
    check_val("t6_c3_streak", dut_c.r_streak,   0);
    rst = 1'b0;
    for (int n = 4; n <= 7; n++) begin
      tick();
      check_val($sformatf("t6_en_%0d", n),  ifc.mem_en, (n == 4));
      check_val($sformatf("t6_ack_%0d", n), ifc.d_ack,  (n == 7));
      check_val($sformatf("t6_if_%0d", n),  ifc.if_ack, 0);
    end
    check_val("t6_rdata", ifc.d_rdata, 32'hCAFE_F00D);
    ifc.d_req = 0; ifc.if_req = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
